// File: rtl/ekf_pkg.sv
// ekf_pkg: shared stage indices, FSM encoding and default result-commit mask
// for the EKF-SLAM stage controller.
package ekf_pkg;

    localparam int STG_PRD = 0;
    localparam int STG_NEW = 1;
    localparam int STG_UPD = 2;

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_INIT   = 4'b0010,
        S_BUSY   = 4'b0100,
        S_COMMIT = 4'b1000
    } state_t;

    // Slice s (bits [s*6 +: 6]) lists the state registers stage s writes:
    // predict -> ch1..3, new-landmark -> ch0..3, update -> all six.
    localparam logic [17:0] DEF_STAGE_RES_MASK = {6'b111111, 6'b001111, 6'b001110};

endpackage

// File: rtl/ekf_state_bank.sv
// ekf_state_bank: NUM_RES x DW persistent state registers with a masked
// parallel load; unmasked channels hold their value.
module ekf_state_bank #(
    parameter int NUM_RES = 6,
    parameter int DW      = 16
) (
    input  logic                  clk,
    input  logic                  sys_rst,
    input  logic                  load,
    input  logic [NUM_RES-1:0]    mask,
    input  logic [NUM_RES*DW-1:0] data_in,
    output logic [NUM_RES*DW-1:0] data_out
);

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            data_out <= '0;
        end else if (load) begin
            for (int i = 0; i < NUM_RES; i++) begin
                if (mask[i]) begin
                    data_out[i*DW +: DW] <= data_in[i*DW +: DW];
                end
            end
        end
    end

endmodule

// File: rtl/ekf_stage_ctrl.sv
// ekf_stage_ctrl: one-hot stage dispatcher and masked result commit for the EKF-SLAM datapath.
// Define STAGE_TIMEOUT_EN to build the BUSY watchdog that drives the sticky err flag.
module ekf_stage_ctrl
    import ekf_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int NUM_RES    = 6,
    parameter int DW         = 16,
    parameter int ROW_LEN    = 10,
    parameter logic [NUM_STAGES*NUM_RES-1:0] STAGE_RES_MASK = DEF_STAGE_RES_MASK,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                  clk,
    input  logic                  sys_rst,
    input  logic [NUM_STAGES-1:0] stage_val,
    output logic [NUM_STAGES-1:0] stage_rdy,
    input  logic [ROW_LEN-1:0]    landmark_num,
    input  logic [ROW_LEN-1:0]    l_k,
    output logic [ROW_LEN-1:0]    lm_num_q,
    output logic [ROW_LEN-1:0]    l_k_q,
    output logic [NUM_STAGES-1:0] init,
    input  logic [NUM_STAGES-1:0] done,
    input  logic [NUM_RES*DW-1:0] result,
    output logic [NUM_RES*DW-1:0] state_q,
    output logic [NUM_STAGES-1:0] stage_done,
    output logic                  busy,
    output logic                  illegal_req,
    output logic                  err
);

    state_t                state;
    state_t                next_state;
    logic [NUM_STAGES-1:0] act_q;
    logic                  req_any;
    logic                  req_onehot;
    logic                  accept;
    logic                  done_hit;
    logic                  commit;
    logic                  timeout;
    logic [NUM_RES-1:0]    load_mask;

    // A request is legal only when exactly one bit is set.
    assign req_any    = |stage_val;
    assign req_onehot = req_any && ((stage_val & (stage_val - NUM_STAGES'(1))) == '0);
    assign accept     = (state == S_IDLE) && req_onehot;
    assign done_hit   = |(done & act_q);
    assign commit     = (state == S_BUSY) && done_hit;

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (accept) next_state = S_INIT;
            S_INIT:   next_state = S_BUSY;
            S_BUSY: begin
                if (done_hit) begin
                    next_state = S_COMMIT;
                end else if (timeout) begin
                    next_state = S_IDLE;
                end
            end
            S_COMMIT: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        stage_rdy = (state == S_IDLE) ? '1 : '0;
        busy      = (state != S_IDLE);
    end

    // Pulses are registered so init lines up with INIT and stage_done with COMMIT.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            init        <= '0;
            stage_done  <= '0;
            illegal_req <= 1'b0;
            act_q       <= '0;
            lm_num_q    <= '0;
            l_k_q       <= '0;
        end else begin
            init        <= accept ? stage_val : '0;
            stage_done  <= commit ? act_q : '0;
            illegal_req <= (state == S_IDLE) && req_any && !req_onehot;
            if (accept) begin
                act_q    <= stage_val;
                lm_num_q <= landmark_num;
                l_k_q    <= l_k;
            end
        end
    end

    always_comb begin
        load_mask = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            if (act_q[s]) begin
                load_mask = load_mask | STAGE_RES_MASK[s*NUM_RES +: NUM_RES];
            end
        end
    end

    ekf_state_bank #(
        .NUM_RES (NUM_RES),
        .DW      (DW)
    ) u_state_bank (
        .clk      (clk),
        .sys_rst  (sys_rst),
        .load     (commit),
        .mask     (load_mask),
        .data_in  (result),
        .data_out (state_q)
    );

`ifdef STAGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] busy_cnt;

    // busy_cnt holds the number of BUSY cycles already elapsed.
    assign timeout = (state == S_BUSY) && !done_hit &&
                     (busy_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            busy_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (state == S_INIT) begin
                busy_cnt <= '0;
            end else if (state == S_BUSY) begin
                busy_cnt <= busy_cnt + CNT_W'(1);
            end
            if (timeout) begin
                err <= 1'b1;
            end
        end
    end
`else
    logic [31:0] unused_timeout_cfg;

    assign unused_timeout_cfg = TIMEOUT_CYC;
    assign timeout            = 1'b0;
    assign err                = 1'b0;
`endif

endmodule

// File: tb/tb_ekf_stage_ctrl.sv
// tb_ekf_stage_ctrl: scoreboard bench for ekf_stage_ctrl; expected commits are queued
// when done is driven and popped when stage_done pulses. Honors STAGE_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_ekf_stage_ctrl;
    import ekf_pkg::*;

    localparam int NS = 3;
    localparam int NR = 6;
    localparam int DW = 16;
    localparam int RL = 10;
    localparam int TO = 20;
    localparam logic [NR-1:0] TB_MASK [NS] = '{6'b001110, 6'b001111, 6'b111111};

    typedef struct {
        logic [NS-1:0]    stg;
        logic [NR*DW-1:0] st;
    } commit_t;

    logic            clk = 1'b0;
    logic            sys_rst;
    logic [NS-1:0]   stage_val;
    logic [NS-1:0]   stage_rdy;
    logic [RL-1:0]   landmark_num;
    logic [RL-1:0]   l_k;
    logic [RL-1:0]   lm_num_q;
    logic [RL-1:0]   l_k_q;
    logic [NS-1:0]   init;
    logic [NS-1:0]   done;
    logic [NR*DW-1:0] result;
    logic [NR*DW-1:0] state_q;
    logic [NS-1:0]   stage_done;
    logic            busy;
    logic            illegal_req;
    logic            err;

    commit_t         sb[$];
    logic [DW-1:0]   model[NR];
    logic [DW-1:0]   res_ch[NR];
    int              checks = 0;
    int              errors = 0;
    logic            mon_en = 1'b0;

    always #5 clk = ~clk;

    ekf_stage_ctrl #(
        .NUM_STAGES  (NS),
        .NUM_RES     (NR),
        .DW          (DW),
        .ROW_LEN     (RL),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .sys_rst      (sys_rst),
        .stage_val    (stage_val),
        .stage_rdy    (stage_rdy),
        .landmark_num (landmark_num),
        .l_k          (l_k),
        .lm_num_q     (lm_num_q),
        .l_k_q        (l_k_q),
        .init         (init),
        .done         (done),
        .result       (result),
        .state_q      (state_q),
        .stage_done   (stage_done),
        .busy         (busy),
        .illegal_req  (illegal_req),
        .err          (err)
    );

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
        return f;
    endfunction

    function automatic logic [NR*DW-1:0] pack_res();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = res_ch[i];
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Applies the stage's write mask to the model and queues the expected commit.
    task automatic expect_commit(input int stg);
        commit_t e;
        for (int i = 0; i < NR; i++) begin
            if (TB_MASK[stg][i]) model[i] = res_ch[i];
        end
        e.stg = NS'(1 << stg);
        e.st  = model_flat();
        sb.push_back(e);
    endtask

    task automatic set_res(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                           input logic [DW-1:0] c2, input logic [DW-1:0] c3,
                           input logic [DW-1:0] c4, input logic [DW-1:0] c5);
        res_ch[0] = c0; res_ch[1] = c1; res_ch[2] = c2;
        res_ch[3] = c3; res_ch[4] = c4; res_ch[5] = c5;
        result = pack_res();
    endtask

    always @(negedge clk) begin
        commit_t e;
        if (mon_en && stage_done !== '0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_commit stage_done=%b expected none", stage_done);
            end else begin
                e = sb.pop_front();
                if (stage_done !== e.stg) begin
                    errors++;
                    $display("[TB] FAIL commit_stage got=%b exp=%b", stage_done, e.stg);
                end
                checks++;
                if (state_q !== e.st) begin
                    errors++;
                    $display("[TB] FAIL commit_state got=%h exp=%h", state_q, e.st);
                end
            end
        end
    end

    task automatic test_reset();
        sys_rst = 1'b1; stage_val = '0; done = '0; landmark_num = '0; l_k = '0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        set_res(0, 0, 0, 0, 0, 0);
        step(); step();
        sys_rst = 1'b0;
        step();
        mon_en = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (stage_rdy !== 3'b111) begin errors++; $display("[TB] FAIL reset_rdy got=%b exp=111", stage_rdy); end
        checks++; if (init !== '0 || stage_done !== '0 || illegal_req !== 1'b0 || err !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_pulses got init=%b sd=%b ill=%b err=%b exp all 0", init, stage_done, illegal_req, err);
        end
        checks++; if (state_q !== '0) begin errors++; $display("[TB] FAIL reset_state got=%h exp=0", state_q); end
        checks++; if (lm_num_q !== '0 || l_k_q !== '0) begin errors++; $display("[TB] FAIL reset_latch got lm=%0d lk=%0d exp 0", lm_num_q, l_k_q); end
    endtask

    task automatic test_newlm();
        stage_val = 3'b010; landmark_num = 10'd6; l_k = 10'd4;
        step();
        checks++; if (init !== 3'b010) begin errors++; $display("[TB] FAIL newlm_init got=%b exp=010", init); end
        checks++; if (busy !== 1'b1 || stage_rdy !== 3'b000) begin errors++; $display("[TB] FAIL newlm_busy got busy=%b rdy=%b exp 1/000", busy, stage_rdy); end
        checks++; if (l_k_q !== 10'd4 || lm_num_q !== 10'd6) begin errors++; $display("[TB] FAIL newlm_latch got lk=%0d lm=%0d exp 4/6", l_k_q, lm_num_q); end
        step();
        stage_val = '0; landmark_num = 10'd99; l_k = 10'd77;
        checks++; if (init !== 3'b000) begin errors++; $display("[TB] FAIL newlm_init_once got=%b exp=000", init); end
        set_res(16'hFFFF, 1, 2, 3, 4, 5);
        done = 3'b010;
        expect_commit(STG_NEW);
        step();
        done = '0;
        checks++; if (stage_rdy !== 3'b000) begin errors++; $display("[TB] FAIL newlm_commit_rdy got=%b exp=000", stage_rdy); end
        step();
        checks++; if (stage_rdy !== 3'b111 || stage_done !== 3'b000) begin errors++; $display("[TB] FAIL newlm_idle got rdy=%b sd=%b exp 111/000", stage_rdy, stage_done); end
        checks++; if (state_q[4*DW +: 2*DW] !== '0 || state_q[0 +: DW] !== 16'hFFFF) begin
            errors++; $display("[TB] FAIL newlm_channels got=%h exp ch0=ffff ch4,5=0", state_q);
        end
        checks++; if (l_k_q !== 10'd4) begin errors++; $display("[TB] FAIL newlm_latch_hold got=%0d exp=4", l_k_q); end
    endtask

    task automatic test_wrong_done();
        stage_val = 3'b001;
        step();
        stage_val = '0;
        step();
        set_res(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666);
        done = 3'b100;
        step();
        done = '0;
        checks++; if (busy !== 1'b1 || stage_done !== '0) begin errors++; $display("[TB] FAIL wrong_done got busy=%b sd=%b exp 1/000", busy, stage_done); end
        checks++; if (state_q !== model_flat()) begin errors++; $display("[TB] FAIL wrong_done_state got=%h exp=%h", state_q, model_flat()); end
        step();
        set_res(16'h1234, 7, 8, 9, 16'hAAAA, 16'hBBBB);
        done = 3'b001;
        expect_commit(STG_PRD);
        step();
        done = '0;
        step();
        checks++; if (state_q[DW +: 3*DW] !== {16'd9, 16'd8, 16'd7} || state_q[0 +: DW] !== 16'hFFFF) begin
            errors++; $display("[TB] FAIL predict_channels got=%h exp ch0=ffff ch1..3=7,8,9", state_q);
        end
    endtask

    task automatic test_update_illegal();
        stage_val = 3'b100;
        step();
        stage_val = '0;
        checks++; if (init !== 3'b100) begin errors++; $display("[TB] FAIL update_init got=%b exp=100", init); end
        step();
        set_res(16'hFFFF, 1, 2, 3, 4, 5);
        done = 3'b100;
        expect_commit(STG_UPD);
        step();
        done = '0;
        step();
        checks++; if (state_q[5*DW +: DW] !== 16'd5 || state_q[4*DW +: DW] !== 16'd4) begin
            errors++; $display("[TB] FAIL update_channels got=%h exp ch4=4 ch5=5", state_q);
        end
        stage_val = 3'b011;
        step();
        stage_val = '0;
        checks++; if (illegal_req !== 1'b1) begin errors++; $display("[TB] FAIL illegal_pulse got=%b exp=1", illegal_req); end
        checks++; if (init !== '0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL illegal_ignored got init=%b busy=%b exp 000/0", init, busy); end
        step();
        checks++; if (illegal_req !== 1'b0) begin errors++; $display("[TB] FAIL illegal_once got=%b exp=0", illegal_req); end
        checks++; if (state_q !== model_flat()) begin errors++; $display("[TB] FAIL illegal_state got=%h exp=%h", state_q, model_flat()); end
    endtask

    task automatic test_reset_mid();
        stage_val = 3'b001; l_k = 10'd3;
        step();
        stage_val = '0;
        step();
        set_res(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 16'h0BAD, 16'hFACE);
        done = 3'b001;
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        checks++; if (busy !== 1'b0 || stage_rdy !== 3'b111) begin errors++; $display("[TB] FAIL rst_mid_idle got busy=%b rdy=%b exp 0/111", busy, stage_rdy); end
        checks++; if (state_q !== '0 || l_k_q !== '0) begin errors++; $display("[TB] FAIL rst_mid_clear got st=%h lk=%0d exp 0", state_q, l_k_q); end
        step();
        done = '0;
        step();
        checks++; if (state_q !== '0 || stage_done !== '0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_mid_nocommit got st=%h sd=%b busy=%b exp 0", state_q, stage_done, busy);
        end
    endtask

    task automatic test_timeout();
        stage_val = 3'b001;
        step();
        stage_val = '0;
        step();
`ifdef STAGE_TIMEOUT_EN
        for (int k = 1; k < TO; k++) step();
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL timeout_early got err=%b busy=%b exp 0/1", err, busy); end
        step();
        checks++; if (err !== 1'b1 || busy !== 1'b0 || stage_rdy !== 3'b111) begin
            errors++; $display("[TB] FAIL timeout_fire got err=%b busy=%b rdy=%b exp 1/0/111", err, busy, stage_rdy);
        end
        checks++; if (state_q !== model_flat()) begin errors++; $display("[TB] FAIL timeout_nocommit got=%h exp=%h", state_q, model_flat()); end
        stage_val = 3'b001;
        step();
        stage_val = '0;
        step();
`else
        for (int k = 0; k < 3 * TO; k++) step();
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL wait_forever got err=%b busy=%b exp 0/1", err, busy); end
`endif
        set_res(16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606);
        done = 3'b001;
        expect_commit(STG_PRD);
        step();
        done = '0;
        step();
`ifdef STAGE_TIMEOUT_EN
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky got=%b exp=1", err); end
`else
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_tied got=%b exp=0", err); end
`endif
    endtask

    task automatic test_back_to_back();
        int s;
        for (int n = 0; n < 6; n++) begin
            s = int'($urandom_range(0, NS - 1));
            stage_val = NS'(1 << s);
            step();
            stage_val = '0;
            checks++; if (init !== NS'(1 << s)) begin errors++; $display("[TB] FAIL b2b_init n=%0d got=%b exp=%b", n, init, NS'(1 << s)); end
            step();
            for (int i = 0; i < NR; i++) res_ch[i] = DW'($urandom);
            result = pack_res();
            done = NS'(1 << s);
            expect_commit(s);
            step();
            done = '0;
            step();
            checks++; if (stage_rdy !== 3'b111) begin errors++; $display("[TB] FAIL b2b_rdy n=%0d got=%b exp=111", n, stage_rdy); end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired got=running exp=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_newlm();
        test_wrong_done();
        test_update_illegal();
        test_reset_mid();
        test_timeout();
        test_back_to_back();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
